// File: rtl/df4iah_v3_pkg.sv
// Shared constants and types for the DF4IAH_V3 bring-up image.
package df4iah_v3_pkg;

    localparam int unsigned BAUD_DIV_DEF = 173;
    localparam int unsigned HB_DIV_DEF   = 10_000_000;

    localparam int unsigned MON_RX_BUSY = 8;
    localparam int unsigned MON_TX_BUSY = 9;
    localparam int unsigned MON_FERR    = 10;
    localparam int unsigned MON_OVR     = 11;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/df4iah_uart_8n1.sv
// UART 8N1 echo engine: RX sampler, one-byte holding register, TX serialiser
// and sticky frame-error / overrun flags.
module df4iah_uart_8n1
    import df4iah_v3_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        cts_o,
    output logic [15:0] monitor_o
);

    localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    // TX drops to IDLE one cycle early so a queued byte starts right after the stop bit.
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(BAUD_DIV - 2);

    logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_good_q, rx_good_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             ferr_q, ferr_d, ovr_q, ovr_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_take;

    always_comb begin
        rx_s1_d    = rx_i;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good_d  = 1'b0;
        ferr_d     = ferr_q;
        case (rx_state_q)
            UART_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = UART_START;
                    rx_cnt_d   = '0;
                end
            end
            UART_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? UART_IDLE : UART_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            UART_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = UART_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = UART_IDLE;
                    if (rx_s2_q) begin
                        rx_good_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // A store and a TX take on the same cycle leave the register full, never overrun.
    always_comb begin
        tx_take     = (tx_state_q == UART_IDLE) && hold_full_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovr_d       = ovr_q;
        rx_byte_d   = rx_byte_q;
        if (tx_take) begin
            hold_full_d = 1'b0;
        end
        if (rx_good_q) begin
            rx_byte_d = rx_shift_q;
            if (hold_full_q && !tx_take) begin
                ovr_d = 1'b1;
            end else begin
                hold_d      = rx_shift_q;
                hold_full_d = 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            UART_IDLE: begin
                if (tx_take) begin
                    tx_state_d = UART_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = hold_q;
                end
            end
            UART_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = UART_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            UART_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = UART_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = UART_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
        endcase
        if (tx_state_d == UART_START) begin
            tx_line_d = 1'b0;
        end else if (tx_state_d == UART_DATA) begin
            tx_line_d = tx_shift_d[0];
        end else begin
            tx_line_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= UART_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_good_q   <= 1'b0;
            rx_byte_q   <= '0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_state_q  <= UART_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_line_q   <= 1'b1;
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_good_q   <= rx_good_d;
            rx_byte_q   <= rx_byte_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_line_q   <= tx_line_d;
        end
    end

    always_comb begin
        monitor_o              = '0;
        monitor_o[7:0]         = rx_byte_q;
        monitor_o[MON_RX_BUSY] = (rx_state_q != UART_IDLE);
        monitor_o[MON_TX_BUSY] = (tx_state_q != UART_IDLE);
        monitor_o[MON_FERR]    = ferr_q;
        monitor_o[MON_OVR]     = ovr_q;
    end

    assign tx_o  = tx_line_q;
    assign cts_o = ~hold_full_q;

endmodule

// File: rtl/df4iah_v3_top.sv
// DF4IAH_V3 bring-up top: UART echo, heartbeat LED, PHY reset release and
// safe idle levels on all unused board peripherals.
module df4iah_v3_top
    import df4iah_v3_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF,
    parameter int unsigned HB_DIV   = HB_DIV_DEF
) (
    input  logic        i_brd_clk,
    input  logic        i_reset_n,
    output logic [3:0]  o_led,
    input  logic        i_uart0_tx,
    output logic        o_uart0_rx,
    input  logic        i_uart0_rts,
    output logic        o_uart0_cts,
    output logic        o_i2c0_scl,
    inout  wire         io_i2c0_sda,
    output logic        o_spi0_sclk,
    output logic        o_spi0_mosi,
    output logic        o_spi0_ss_n,
    input  logic        i_spi0_miso,
    output logic [3:0]  o_sram_cs_n,
    output logic        o_sram_read_n,
    output logic        o_sram_write_n,
    output logic [20:0] o_sram_addr,
    inout  wire  [7:0]  io_sram_data,
    input  logic        i_mtx_clk,
    input  logic        i_mrx_clk,
    output logic [3:0]  o_mtxd,
    output logic        o_mtxen,
    output logic        o_mtxerr,
    input  logic [3:0]  i_mrxd,
    input  logic        i_mrxdv,
    input  logic        i_mrxerr,
    input  logic        i_mcoll,
    input  logic        i_mcrs,
    inout  wire         io_md,
    output logic        o_mdc,
    output logic        o_phy_reset_n,
    input  logic        altera_reserved_tck,
    input  logic        altera_reserved_tdi,
    input  logic        altera_reserved_tms,
    output logic        altera_reserved_tdo,
    output logic [15:0] o_monitor
);

    localparam int unsigned HB_W = (HB_DIV > 2) ? $clog2(HB_DIV) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_DIV - 1);

    logic            phy_s1_q, phy_s1_d, phy_s2_q, phy_s2_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            hb_led_q, hb_led_d;
    logic [15:0]     monitor;
    logic            unused_inputs;

    always_comb begin
        phy_s1_d = 1'b1;
        phy_s2_d = phy_s1_q;
        hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + HB_W'(1);
        hb_led_d = hb_led_q ^ (hb_cnt_q == HB_LAST);
    end

    always_ff @(posedge i_brd_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phy_s1_q <= 1'b0;
            phy_s2_q <= 1'b0;
            hb_cnt_q <= '0;
            hb_led_q <= 1'b0;
        end else begin
            phy_s1_q <= phy_s1_d;
            phy_s2_q <= phy_s2_d;
            hb_cnt_q <= hb_cnt_d;
            hb_led_q <= hb_led_d;
        end
    end

    df4iah_uart_8n1 #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk       (i_brd_clk),
        .rst_n     (i_reset_n),
        .rx_i      (i_uart0_tx),
        .tx_o      (o_uart0_rx),
        .cts_o     (o_uart0_cts),
        .monitor_o (monitor)
    );

    assign o_monitor     = monitor;
    assign o_led         = {phy_s2_q, monitor[MON_FERR], monitor[MON_TX_BUSY], hb_led_q};
    assign o_phy_reset_n = phy_s2_q;

    assign o_i2c0_scl          = 1'b1;
    assign io_i2c0_sda         = 1'bz;
    assign o_spi0_sclk         = 1'b0;
    assign o_spi0_mosi         = 1'b0;
    assign o_spi0_ss_n         = 1'b1;
    assign o_sram_cs_n         = 4'hF;
    assign o_sram_read_n       = 1'b1;
    assign o_sram_write_n      = 1'b1;
    assign o_sram_addr         = '0;
    assign io_sram_data        = 8'bzzzz_zzzz;
    assign o_mtxd              = 4'h0;
    assign o_mtxen             = 1'b0;
    assign o_mtxerr            = 1'b0;
    assign io_md               = 1'bz;
    assign o_mdc               = 1'b0;
    assign altera_reserved_tdo = 1'b0;

    assign unused_inputs = ^{i_uart0_rts, i_spi0_miso, i_mtx_clk, i_mrx_clk, i_mrxd,
                             i_mrxdv, i_mrxerr, i_mcoll, i_mcrs,
                             altera_reserved_tck, altera_reserved_tdi, altera_reserved_tms};

endmodule

// File: tb/tb_df4iah_v3_top.sv
// Directed bench for df4iah_v3_top: expected echo bytes are queued when sent
// and checked by a serial decoder watching o_uart0_rx.
`timescale 1ns/1ps
module tb_df4iah_v3_top;

    localparam int BD    = 173;
    localparam int FRAME = 10 * BD;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_uart0_tx = 1'b1;
    logic [3:0]  o_led;
    logic        o_uart0_rx, o_uart0_cts, o_i2c0_scl;
    logic        o_spi0_sclk, o_spi0_mosi, o_spi0_ss_n;
    logic [3:0]  o_sram_cs_n;
    logic        o_sram_read_n, o_sram_write_n;
    logic [20:0] o_sram_addr;
    logic [3:0]  o_mtxd;
    logic        o_mtxen, o_mtxerr, o_mdc, o_phy_reset_n, altera_reserved_tdo;
    logic [15:0] o_monitor;
    wire         io_i2c0_sda;
    wire  [7:0]  io_sram_data;
    wire         io_md;

    int          checks = 0;
    int          passes = 0;
    int          frames_seen = 0;
    int          last_start_len = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  exp_q[$];
    logic        samp [0:FRAME-1];

    always #25 clk = ~clk;

    df4iah_v3_top #(.BAUD_DIV(BD), .HB_DIV(4)) dut (
        .i_brd_clk(clk), .i_reset_n(i_reset_n), .o_led(o_led),
        .i_uart0_tx(i_uart0_tx), .o_uart0_rx(o_uart0_rx), .i_uart0_rts(1'b0),
        .o_uart0_cts(o_uart0_cts), .o_i2c0_scl(o_i2c0_scl), .io_i2c0_sda(io_i2c0_sda),
        .o_spi0_sclk(o_spi0_sclk), .o_spi0_mosi(o_spi0_mosi), .o_spi0_ss_n(o_spi0_ss_n),
        .i_spi0_miso(1'b0), .o_sram_cs_n(o_sram_cs_n), .o_sram_read_n(o_sram_read_n),
        .o_sram_write_n(o_sram_write_n), .o_sram_addr(o_sram_addr), .io_sram_data(io_sram_data),
        .i_mtx_clk(1'b0), .i_mrx_clk(1'b0), .o_mtxd(o_mtxd), .o_mtxen(o_mtxen),
        .o_mtxerr(o_mtxerr), .i_mrxd(4'h0), .i_mrxdv(1'b0), .i_mrxerr(1'b0),
        .i_mcoll(1'b0), .i_mcrs(1'b0), .io_md(io_md), .o_mdc(o_mdc),
        .o_phy_reset_n(o_phy_reset_n), .altera_reserved_tck(1'b0),
        .altera_reserved_tdi(1'b0), .altera_reserved_tms(1'b0),
        .altera_reserved_tdo(altera_reserved_tdo), .o_monitor(o_monitor)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic v);
        i_uart0_tx = v;
        repeat (BD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int c = 0;
        while (frames_seen < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, frames_seen, n);
    endtask

    task automatic measure_hb(output int len);
        logic h;
        int   c;
        @(negedge clk);
        h = o_led[0];
        c = 0;
        while (o_led[0] === h && c < 10) begin @(negedge clk); c++; end
        h = o_led[0];
        c = 0;
        while (o_led[0] === h && c < 10) begin @(negedge clk); c++; end
        len = c;
    endtask

    // Serial decoder: captures a whole frame cycle by cycle, then checks it.
    initial begin
        logic [7:0] got, want;
        int         run;
        forever begin
            @(negedge clk);
            if (i_reset_n && o_uart0_rx === 1'b0) begin
                samp[0] = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    samp[i] = o_uart0_rx;
                end
                for (int i = 0; i < 8; i++) got[i] = samp[(i + 1) * BD + BD / 2];
                run = 0;
                for (int i = 0; i < FRAME; i++) if (samp[i] == 1'b0 && run == i) run = i + 1;
                if (mon_en) begin
                    last_start_len = run;
                    check("echo_start_bit", samp[BD / 2], 1'b0);
                    check("echo_stop_bit", samp[9 * BD + BD / 2], 1'b1);
                    check("echo_pending", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        check("echo_byte", got, want);
                    end
                end
                frames_seen++;
            end
        end
    end

    initial begin
        logic [15:0] saved;
        int          c;
        int          hb;

        // Reset held for 10 us
        #10000;
        check("rst_led", o_led, 4'h0);
        check("rst_uart_rx", o_uart0_rx, 1'b1);
        check("rst_cts", o_uart0_cts, 1'b1);
        check("rst_spi_ss_n", o_spi0_ss_n, 1'b1);
        check("rst_sram_cs_n", o_sram_cs_n, 4'hF);
        check("rst_phy_reset_n", o_phy_reset_n, 1'b0);
        check("rst_monitor", o_monitor, 16'h0000);
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("phy_released", o_phy_reset_n, 1'b1);
        check("alive_led", o_led[3], 1'b1);

        // Echo 0xA5
        repeat (20) @(negedge clk);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_frames(1, 12 * BD, "echo_a5_seen");
        check("echo_a5_start_len", last_start_len, BD);
        check("mon_byte_a5", o_monitor[7:0], 8'hA5);
        check("tx_idle_after", o_led[1], 1'b0);
        check("cts_after_echo", o_uart0_cts, 1'b1);
        check("ovr_after_echo", o_monitor[11], 1'b0);

        // Frame error on 0x3C
        send_byte(8'h3C, 1'b0);
        i_uart0_tx = 1'b1;
        repeat (12 * BD) @(negedge clk);
        check("ferr_no_echo", frames_seen, 1);
        check("ferr_flag", o_monitor[10], 1'b1);
        check("ferr_led", o_led[2], 1'b1);
        check("ferr_byte_kept", o_monitor[7:0], 8'hA5);

        // 40-cycle glitch
        saved = o_monitor;
        i_uart0_tx = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_rx_busy", o_monitor[8], 1'b1);
        i_uart0_tx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_rx_idle", o_monitor[8], 1'b0);
        check("glitch_monitor", o_monitor, saved);
        check("glitch_no_echo", frames_seen, 1);

        // Back-to-back 0x00, 0xFF
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_frames(3, 12 * BD, "b2b_seen");
        check("b2b_no_overrun", o_monitor[11], 1'b0);
        check("b2b_last_byte", o_monitor[7:0], 8'hFF);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Heartbeat with HB_DIV = 4
        measure_hb(hb);
        check("hb_period_a", hb, 4);
        measure_hb(hb);
        check("hb_period_b", hb, 4);

        // Reset during the start bit of an echo
        mon_en = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        i_uart0_tx = 1'b1;
        c = 0;
        while (o_led[1] !== 1'b1 && c < 2 * BD) begin @(negedge clk); c++; end
        check("midtx_busy", o_led[1], 1'b1);
        repeat (20) @(negedge clk);
        check("midtx_start_low", o_uart0_rx, 1'b0);
        #10;
        i_reset_n = 1'b0;
        #1;
        check("midtx_rst_line", o_uart0_rx, 1'b1);
        check("midtx_rst_led", o_led, 4'h0);
        check("midtx_rst_monitor", o_monitor, 16'h0000);
        check("midtx_rst_phy", o_phy_reset_n, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/df4iah_v3_top.md
# df4iah_v3_top

Board-level top for the DF4IAH_V3 Cyclone III board in a single clock domain. It provides a UART 8N1 echo service with status/monitor outputs, an LED heartbeat and a PHY reset sequencer. It drives safe idle levels on every SRAM, SPI, I2C, Ethernet and JTAG pin. This top is the bring-up image that a simulation bench instantiates directly.

## Interface
- BAUD_DIV, 173: clock cycles per UART bit (20 MHz / 115200).
- HB_DIV, 10_000_000: clock cycles per heartbeat LED toggle.
- One clock; reset is asynchronous and active-low.
- i_brd_clk  in  1  20 MHz board clock; the only clock.
- i_reset_n  in  1  async active-low reset.
- o_led  out  4  [0] heartbeat, [1] tx busy, [2] frame-error sticky, [3] alive.
- i_uart0_tx / o_uart0_rx  in / out  1 / 1  host→FPGA serial / FPGA→host serial.
- i_uart0_rts  in  1  ignored.
- o_uart0_cts  out  1  1 = holding register empty.
- o_i2c0_scl  out  1  constant 1.
- io_i2c0_sda  inout  1  always Z.
- o_spi0_sclk / o_spi0_mosi / o_spi0_ss_n  out  1 each  constant 0 / 0 / 1.
- i_spi0_miso  in  1  ignored.
- o_sram_cs_n  out  4  constant 4'hF.
- o_sram_read_n / o_sram_write_n  out  1 each  constant 1.
- o_sram_addr  out  21  constant 0.
- io_sram_data  inout  8  always Z.
- i_mtx_clk, i_mrx_clk  in  1 each  ignored; nothing is clocked by them.
- o_mtxd  out  4  constant 0.
- o_mtxen, o_mtxerr  out  1 each  constant 0.
- i_mrxd[3:0], i_mrxdv, i_mrxerr, i_mcoll, i_mcrs  in  ignored.
- io_md  inout  1  always Z.
- o_mdc  out  1  constant 0.
- o_phy_reset_n  out  1  PHY reset, released after the design leaves reset.
- altera_reserved_tck/tdi/tms  in  1 each  ignored.
- altera_reserved_tdo  out  1  constant 0.
- o_monitor  out  16  [7:0] last good RX byte, [8] rx busy, [9] tx busy, [10] frame error, [11] overrun, [15:12] 0.

## Operation
- **Reset values.** Asserting reset forces all registered outputs to reset values immediately, including mid-frame.
  - o_led = 0, o_monitor = 0, o_uart0_rx = 1, o_uart0_cts = 1, o_phy_reset_n = 0.
  - Any in-flight RX/TX frame is abandoned.
- **PHY reset.** o_phy_reset_n is a 2-flop synchroniser of constant 1, cleared by reset.
- **Alive LED.** o_led[3] follows the same synchroniser.
- **RX synchronisation.** i_uart0_tx passes through a 2-flop synchroniser (reset value 1).
- **RX state machine.** States IDLE → START → DATA → STOP.
  - IDLE: a synchronised 1→0 edge enters START.
  - START: samples at BAUD_DIV/2 (integer divide). If the line is high, return to IDLE (glitch reject).
  - DATA: samples 8 bits LSB-first, each BAUD_DIV cycles after the previous sample.
  - STOP: samples the stop bit. If it is 1, the byte is good. If it is 0, set frame-error sticky, discard the byte, and return to IDLE.
- **Good byte.** Write it to monitor[7:0].
  - If the holding register is empty, store it there.
  - If the holding register is full, drop the byte and set overrun sticky.
- **TX state machine.** States IDLE → START → DATA → STOP.
  - Leaves IDLE when the holding register is full, emptying it on the same cycle.
  - Sends one start bit (0), 8 data bits LSB-first and one stop bit (1), each exactly BAUD_DIV cycles.
- **Sticky flags.** Frame-error and overrun clear only on reset. o_led[2] mirrors frame-error.
- **Heartbeat.** A counter wraps at HB_DIV−1, and o_led[0] toggles on each wrap.
- **Status mirrors.**
  - o_led[1] = monitor[9] = TX not IDLE.
  - monitor[8] = RX not IDLE.

## Timing
- RX sample points: start bit at edge + BAUD_DIV/2 + 2 sync cycles, then every BAUD_DIV cycles.
- A good byte reaches the holding register 1 cycle after the stop-bit sample.
- TX start bit begins on the following cycle (echo latency ≈ 9.5 bit times + 3 cycles).
- A TX frame lasts 10×BAUD_DIV cycles. TX returns to IDLE at the last cycle of the stop bit.
- Back-to-back RX frames never overrun, because the holding register decouples RX from TX.
- If a good byte lands on the same cycle TX empties the holding register, the store wins and no overrun is flagged.

## Structure
- Shared package df4iah_v3_pkg holds:
  - the default BAUD_DIV and HB_DIV;
  - the monitor bit indices;
  - the UART state enum (IDLE, START, DATA, STOP).
- One sub-module, df4iah_uart_8n1, contains the RX engine, holding register, TX engine and sticky flags.
- The top contains the tie-offs, heartbeat and PHY-reset synchroniser.

## Test plan
- **Reset.** Hold reset 10 µs → o_led = 0, o_uart0_rx = 1, o_spi0_ss_n = 1, o_sram_cs_n = F, o_phy_reset_n = 0, io_sram_data = Z. After release, o_phy_reset_n = 1 and o_led[3] = 1 within 3 cycles.
- **Echo.** Send 0xA5 at BAUD_DIV = 173 → o_uart0_rx emits a 0xA5 frame (10×173 cycles) and monitor[7:0] = A5.
- **Frame error.** Send 0x3C with stop bit 0 → no echo, monitor[10] = 1, o_led[2] = 1.
- **Glitch reject.** Drive a 40-cycle low pulse → RX returns to IDLE, no echo, monitor unchanged.
- **Back-to-back.** Send 0x00 then 0xFF with no gap → both echoed in order, monitor[11] = 0.
- **Heartbeat and reset mid-frame.** With HB_DIV = 4, o_led[0] toggles every 4 cycles. Asserting reset mid-TX forces o_uart0_rx = 1 at once.
